branch_predictor: RTL

//  gshare direction predictor feeding branch unit `b`; drives its prediction_begin, pattern_begin, addr_on_failure_in at issue.

---
 rtl/branch_predictor.sv | 137 +++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// gshare direction predictor with speculative and committed global history.
// PHT is swept to weakly-not-taken after reset before lookups are accepted.
module branch_predictor #(
  parameter int PATTERN_WIDTH  = 8,
  parameter int INST_MEM_WIDTH = 14
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      lookup_valid,
  input  logic                      lookup_fire,
  input  logic [INST_MEM_WIDTH-1:0] lookup_pc,
  input  logic [INST_MEM_WIDTH-1:0] lookup_target,
  input  logic [INST_MEM_WIDTH-1:0] lookup_fallthrough,
  output logic                      lookup_ready,
  output logic [1:0]                prediction,
  output logic [PATTERN_WIDTH-1:0]  pattern,
  output logic [INST_MEM_WIDTH-1:0] addr_on_failure,
  input  logic                      commit,
  input  logic                      commit_failure,
  input  logic [1:0]                commit_prediction,
  input  logic [PATTERN_WIDTH-1:0]  commit_pattern,
  output logic [31:0]               stat_commits,
  output logic [31:0]               stat_failures
);
  localparam int PW    = PATTERN_WIDTH;
  localparam int IMW   = INST_MEM_WIDTH;
  localparam int DEPTH = 1 << PW;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [PW-1:0]   init_idx_q;
  logic [PW-1:0]   spec_hist_q;
  logic [PW-1:0]   commit_hist_q;
  logic [PW-1:0]   commit_hist_d;
  logic [1:0]      pht [DEPTH];
  logic [31:0]     commits_q;
  logic [31:0]     failures_q;
  logic            run;
  logic            do_commit;
  logic            do_flush;
  logic            do_fire;
  logic            taken;
  logic [1:0]      cnt_old;
  logic [1:0]      cnt_new;
  logic            unused_ok;

  assign unused_ok = ^{lookup_valid,
                       lookup_pc[IMW-1:PW],
                       commit_prediction[0]};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  // Next state: leave INIT once the last PHT entry is written
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:    if (init_idx_q == '1) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // FSM outputs
  always_comb begin
    run          = (state_q == RUN);
    lookup_ready = run;
  end

  // Lookup and commit datapath
  always_comb begin
    pattern         = lookup_pc[PW-1:0] ^ spec_hist_q;
    prediction      = pht[pattern];
    addr_on_failure = prediction[1] ? lookup_fallthrough
                                    : lookup_target;
    do_commit = run && commit;
    do_flush  = run && flush;
    do_fire   = run && lookup_fire;
    taken     = commit_failure ^ commit_prediction[1];
    cnt_old   = pht[commit_pattern];
    cnt_new   = cnt_old;
    if (taken && cnt_old != 2'b11)  cnt_new = cnt_old + 2'b01;
    if (!taken && cnt_old != 2'b00) cnt_new = cnt_old - 2'b01;
    commit_hist_d = commit_hist_q;
    if (do_commit) commit_hist_d = {commit_hist_q[PW-2:0], taken};
  end

  // PHT: init sweep, then trained from the stored counter at commit
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == INIT)  pht[init_idx_q]     <= 2'b01;
      else if (do_commit)   pht[commit_pattern] <= cnt_new;
    end
  end

  // Init sweep index
  always_ff @(posedge clk) begin
    if (!rst_n)                init_idx_q <= '0;
    else if (state_q == INIT)  init_idx_q <= init_idx_q + 1'b1;
  end

  // Histories; flush restores speculative from committed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spec_hist_q   <= '0;
      commit_hist_q <= '0;
    end else begin
      commit_hist_q <= commit_hist_d;
      if (do_flush)     spec_hist_q <= commit_hist_d;
      else if (do_fire) spec_hist_q <= {spec_hist_q[PW-2:0], prediction[1]};
    end
  end

  // Commit statistics, wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      commits_q  <= '0;
      failures_q <= '0;
    end else if (do_commit) begin
      commits_q  <= commits_q + 32'd1;
      failures_q <= failures_q + {31'd0, commit_failure};
    end
  end

  assign stat_commits  = commits_q;
  assign stat_failures = failures_q;

endmodule
